edge_event_reader: RTL and testbench

Consumer for the sticky falling-edge vector produced by `edge_capture`. It watches the 32-bit `edge_o` vector and reports each newly set bit exactly once, as a bit index over a valid/ready handshake, lowest index first. It keeps its own served mask, because upstream bits clear only on reset. It sits between `edge_capture` and any event-driven consumer such as an interrupt or logging unit, and shares that block's clock and reset.

---
 rtl/edge_event_reader.sv | 105 ++++++++++
 tb/tb_edge_event_reader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_reader.sv
// Edge event reader: turns a sticky edge vector into a stream of lane indices.
// Each lane is reported once per reset interval, lowest pending index first,
// over a valid/ready handshake. A private served mask tracks acceptances
// because upstream edge bits only clear on reset.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | nothing presented; waiting for any unserved edge bit
// S_PRESENT | r_idx is presented; held stable until accepted (no preemption)
module edge_event_reader #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] edge_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IDXW-1:0]  evt_idx_o,
  output logic [IDXW:0]    evt_count_o,
  output logic             pending_o,
  output logic             all_done_o
);

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_served;
  logic [IDXW-1:0]  r_idx;
  logic [IDXW:0]    r_count;
  logic             r_valid;

  logic [WIDTH-1:0] w_pending;
  logic [WIDTH-1:0] w_sel_mask;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_enc_in;
  logic [IDXW-1:0]  w_enc_idx;
  logic             w_enc_any;
  logic             w_accept;

  assign w_pending  = edge_i & ~r_served;
  assign w_sel_mask = {{(WIDTH-1){1'b0}}, 1'b1} << r_idx;
  assign w_next     = w_pending & ~w_sel_mask;
  assign w_accept   = r_valid & evt_ready_i;

  // One encoder serves both the idle load and the back-to-back reload;
  // while presenting, the current lane is masked out of its input.
  assign w_enc_in = (r_state == S_PRESENT) ? w_next : w_pending;

  // Priority encoder: lowest set bit of w_enc_in.
  always_comb begin
    w_enc_idx = '0;
    w_enc_any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_enc_in[i]) begin
        w_enc_idx = IDXW'(i);
        w_enc_any = 1'b1;
      end
    end
  end

  // Handshake FSM with registered valid/index/count and served mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_served <= '0;
      r_idx    <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_enc_any) begin
            r_idx   <= w_enc_idx;
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (w_accept) begin
            r_served <= r_served | w_sel_mask;
            r_count  <= r_count + {{IDXW{1'b0}}, 1'b1};
            if (w_enc_any) begin
              r_idx <= w_enc_idx;
            end else begin
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign evt_valid_o = r_valid;
  assign evt_idx_o   = r_idx;
  assign evt_count_o = r_count;
  assign pending_o   = |w_pending;
  assign all_done_o  = &r_served;

endmodule

// File: tb/tb_edge_event_reader.sv
// Bench for edge_event_reader: behavioural model checked every cycle, plus
// directed scenarios with hand-computed expectations and a random phase.
module tb_edge_event_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] edge_i = '0;
  logic        evt_ready_i = 1'b0;
  logic        evt_valid_o;
  logic [4:0]  evt_idx_o;
  logic [5:0]  evt_count_o;
  logic        pending_o;
  logic        all_done_o;

  int n_checks = 0;
  int n_fail   = 0;

  edge_event_reader #(.WIDTH(32), .IDXW(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .edge_i      (edge_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_idx_o   (evt_idx_o),
    .evt_count_o (evt_count_o),
    .pending_o   (pending_o),
    .all_done_o  (all_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: which lane is on offer, which lanes are done, how many.
  bit          m_init = 1'b0;
  bit          m_valid;
  int          m_idx;
  logic [31:0] m_served;
  int          m_count;

  always @(posedge clk) begin
    logic [31:0] srv;
    int lo;
    if (reset) begin
      m_init   <= 1'b1;
      m_valid  <= 1'b0;
      m_idx    <= 0;
      m_served <= '0;
      m_count  <= 0;
    end else if (m_init) begin
      if (m_valid && evt_ready_i) begin
        srv = m_served | (32'h1 << m_idx);
        m_served <= srv;
        m_count  <= m_count + 1;
        lo = lowest(edge_i & ~srv);
        if (lo >= 0) m_idx <= lo;
        else m_valid <= 1'b0;
      end else if (!m_valid) begin
        lo = lowest(edge_i & ~m_served);
        if (lo >= 0) begin
          m_valid <= 1'b1;
          m_idx   <= lo;
        end
      end
    end
  end

  // Accepted-index log taken from the DUT, used by the directed scenarios.
  int acc_log[$];

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("valid", 64'(evt_valid_o), 64'(m_valid));
      if (m_valid) chk("idx", 64'(evt_idx_o), 64'(m_idx));
      chk("count", 64'(evt_count_o), 64'(m_count));
      chk("pending", 64'(pending_o), 64'(|(edge_i & ~m_served)));
      chk("all_done", 64'(all_done_o), 64'(&m_served));
      if (evt_valid_o && evt_ready_i && !reset) acc_log.push_back(int'(evt_idx_o));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    edge_i = '0;
    tick(1);
    reset  = 1'b0;
  endtask

  initial begin
    logic [7:0]  data_seq [5];
    logic [7:0]  prev_data;
    logic [31:0] cap;
    int          e_a [4];

    // Reset and quiet input.
    evt_ready_i = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(5);
    chk("s1_valid", 64'(evt_valid_o), 64'd0);
    chk("s1_count", 64'(evt_count_o), 64'd0);
    chk("s1_pending", 64'(pending_o), 64'd0);

    // Sticky falling-edge capture of a data sequence feeding the reader.
    data_seq = '{8'h00, 8'hA6, 8'hBC, 8'hBA, 8'hEB};
    prev_data = 8'h00;
    cap = '0;
    evt_ready_i = 1'b1;
    acc_log.delete();
    for (int i = 0; i < 5; i++) begin
      cap = cap | {24'h0, prev_data & ~data_seq[i]};
      prev_data = data_seq[i];
      edge_i = cap;
      tick(1);
    end
    tick(3);
    chk("s2_edge_vec", 64'(edge_i), 64'h16);
    chk("s2_n_events", 64'(acc_log.size()), 64'd3);
    if (acc_log.size() == 3) begin
      chk("s2_ev0", 64'(acc_log[0]), 64'd1);
      chk("s2_ev1", 64'(acc_log[1]), 64'd2);
      chk("s2_ev2", 64'(acc_log[2]), 64'd4);
    end
    chk("s2_count", 64'(evt_count_o), 64'd3);
    chk("s2_pending", 64'(pending_o), 64'd0);

    // Several lanes in one step: back-to-back, valid never drops.
    do_reset();
    e_a = '{0, 5, 10, 15};
    evt_ready_i = 1'b1;
    edge_i = 32'h0000_8421;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      chk("s3_valid", 64'(evt_valid_o), 64'd1);
      chk("s3_idx", 64'(evt_idx_o), 64'(e_a[i]));
      tick(1);
    end
    chk("s3_valid_end", 64'(evt_valid_o), 64'd0);
    chk("s3_count", 64'(evt_count_o), 64'd4);

    // Backpressure: presented lane holds even when a lower lane sets.
    do_reset();
    evt_ready_i = 1'b0;
    edge_i = 32'h10;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      chk("s4_hold_valid", 64'(evt_valid_o), 64'd1);
      chk("s4_hold_idx", 64'(evt_idx_o), 64'd4);
      tick(1);
    end
    edge_i = 32'h11;
    tick(2);
    chk("s4_nopreempt_idx", 64'(evt_idx_o), 64'd4);
    acc_log.delete();
    evt_ready_i = 1'b1;
    tick(3);
    chk("s4_n_events", 64'(acc_log.size()), 64'd2);
    if (acc_log.size() == 2) begin
      chk("s4_ev0", 64'(acc_log[0]), 64'd4);
      chk("s4_ev1", 64'(acc_log[1]), 64'd0);
    end
    chk("s4_count", 64'(evt_count_o), 64'd2);

    // Reset in the middle of an accepting handshake.
    do_reset();
    evt_ready_i = 1'b0;
    edge_i = 32'h08;
    for (int k = 0; k < 5 && !evt_valid_o; k++) tick(1);
    chk("s5_presented", 64'(evt_valid_o), 64'd1);
    chk("s5_idx", 64'(evt_idx_o), 64'd3);
    reset = 1'b1;
    evt_ready_i = 1'b1;
    tick(1);
    reset  = 1'b0;
    edge_i = '0;
    chk("s5_valid_after_rst", 64'(evt_valid_o), 64'd0);
    chk("s5_count_after_rst", 64'(evt_count_o), 64'd0);
    tick(3);
    chk("s5_quiet", 64'(evt_valid_o), 64'd0);
    evt_ready_i = 1'b0;
    edge_i = 32'h08;
    tick(1);
    chk("s5_represent", 64'(evt_valid_o), 64'd1);
    chk("s5_represent_idx", 64'(evt_idx_o), 64'd3);
    evt_ready_i = 1'b1;
    tick(1);
    chk("s5_count", 64'(evt_count_o), 64'd1);

    // All lanes at once.
    do_reset();
    evt_ready_i = 1'b1;
    acc_log.delete();
    edge_i = 32'hFFFF_FFFF;
    tick(33);
    chk("s6_count", 64'(evt_count_o), 64'd32);
    chk("s6_all_done", 64'(all_done_o), 64'd1);
    chk("s6_valid", 64'(evt_valid_o), 64'd0);
    chk("s6_n_events", 64'(acc_log.size()), 64'd32);
    if (acc_log.size() == 32) begin
      for (int i = 0; i < 32; i++) chk("s6_order", 64'(acc_log[i]), 64'(i));
    end

    // Random phase: sticky growth, occasional drops, random ready, resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(149) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(3) == 0) edge_i = edge_i | (32'h1 << $urandom_range(31));
        if ($urandom_range(39) == 0) edge_i = edge_i | $urandom;
        if ($urandom_range(24) == 0) edge_i = edge_i & $urandom;
        evt_ready_i = ($urandom_range(2) != 0);
        tick(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
